// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction-fetch sequencer between the program counter and instruction memory
// One fetch in flight; the fetched word is held for decode under a valid/ready handshake.
module fetch_sequencer #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_run,
    input  logic              i_flush,
    input  logic              i_replay,
    input  logic [ADDR_W-1:0] i_pc_in,
    output logic              o_pc_oe,
    output logic              o_pc_inc,
    output logic              o_pc_dec,
    output logic              o_pc_flush,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_instr_valid,
    input  logic              i_instr_ready,
    output logic [DATA_W-1:0] o_instr_data,
    output logic [ADDR_W-1:0] o_instr_pc,
    output logic [CNT_W-1:0]  o_fetch_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_mem_req,     w_mem_req_nxt;
    logic [ADDR_W-1:0]  r_mem_addr,    w_mem_addr_nxt;
    logic               r_instr_valid, w_instr_valid_nxt;
    logic [DATA_W-1:0]  r_instr_data,  w_instr_data_nxt;
    logic [ADDR_W-1:0]  r_instr_pc,    w_instr_pc_nxt;
    logic [CNT_W-1:0]   r_fetch_cnt,   w_fetch_cnt_nxt;
    logic               r_pc_inc,      w_pc_inc_nxt;
    logic               r_pc_dec,      w_pc_dec_nxt;
    logic               r_pc_flush,    w_pc_flush_nxt;

    // While a PC pulse is still being applied the counter has not settled,
    // so IDLE waits one more cycle before sampling pc_in.
    logic w_pc_settling;
    logic w_issue;
    assign w_pc_settling = r_pc_inc | r_pc_dec | r_pc_flush;
    assign w_issue       = (r_state == S_IDLE) && i_run && !i_flush && !w_pc_settling;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= S_IDLE;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
            r_instr_valid <= 1'b0;
            r_instr_data  <= '0;
            r_instr_pc    <= '0;
            r_fetch_cnt   <= '0;
            r_pc_inc      <= 1'b0;
            r_pc_dec      <= 1'b0;
            r_pc_flush    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_mem_req     <= w_mem_req_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_instr_data  <= w_instr_data_nxt;
            r_instr_pc    <= w_instr_pc_nxt;
            r_fetch_cnt   <= w_fetch_cnt_nxt;
            r_pc_inc      <= w_pc_inc_nxt;
            r_pc_dec      <= w_pc_dec_nxt;
            r_pc_flush    <= w_pc_flush_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_issue) w_state_nxt = S_REQ;
            S_REQ: begin
                if (i_flush)        w_state_nxt = i_mem_ack ? S_IDLE : S_DRAIN;
                else if (i_mem_ack) w_state_nxt = S_HOLD;
            end
            S_HOLD:  if (i_flush || i_replay || i_instr_ready) w_state_nxt = S_IDLE;
            S_DRAIN: if (i_mem_ack) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_mem_req_nxt     = r_mem_req;
        w_mem_addr_nxt    = r_mem_addr;
        w_instr_valid_nxt = r_instr_valid;
        w_instr_data_nxt  = r_instr_data;
        w_instr_pc_nxt    = r_instr_pc;
        w_fetch_cnt_nxt   = r_fetch_cnt;
        w_pc_inc_nxt      = 1'b0;
        w_pc_dec_nxt      = 1'b0;
        w_pc_flush_nxt    = i_flush;
        if (i_flush) w_instr_valid_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_mem_req_nxt  = 1'b1;
                    w_mem_addr_nxt = i_pc_in;
                end
            end
            S_REQ: begin
                if (i_mem_ack) begin
                    w_mem_req_nxt = 1'b0;
                    if (!i_flush) begin
                        w_instr_valid_nxt = 1'b1;
                        w_instr_data_nxt  = i_mem_rdata;
                        w_instr_pc_nxt    = r_mem_addr;
                        w_pc_inc_nxt      = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (!i_flush) begin
                    if (i_replay) begin
                        w_instr_valid_nxt = 1'b0;
                        w_pc_dec_nxt      = 1'b1;
                    end else if (i_instr_ready) begin
                        w_instr_valid_nxt = 1'b0;
                        w_fetch_cnt_nxt   = r_fetch_cnt + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (i_mem_ack) w_mem_req_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    assign o_pc_oe       = (r_state == S_IDLE);
    assign o_pc_inc      = r_pc_inc;
    assign o_pc_dec      = r_pc_dec;
    assign o_pc_flush    = r_pc_flush;
    assign o_mem_req     = r_mem_req;
    assign o_mem_addr    = r_mem_addr;
    assign o_instr_valid = r_instr_valid;
    assign o_instr_data  = r_instr_data;
    assign o_instr_pc    = r_instr_pc;
    assign o_fetch_cnt   = r_fetch_cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
// Bench holds a program-counter model, a random-latency memory and a transaction-level reference.
module tb_fetch_sequencer;
    localparam int AW = 12;
    localparam int DW = 16;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          run = 0, flush = 0, replay = 0, ready = 0;
    logic [AW-1:0] pc_in;
    logic          ack;
    logic [DW-1:0] rdata = '0;
    logic          pc_oe, pc_inc, pc_dec, pc_flush, mem_req, instr_valid;
    logic [AW-1:0] mem_addr, instr_pc;
    logic [DW-1:0] instr_data;
    logic [CW-1:0] fetch_cnt;

    int checks = 0;
    int failures = 0;

    fetch_sequencer #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .i_clock(clk), .i_reset(rst_n), .i_run(run), .i_flush(flush), .i_replay(replay),
        .i_pc_in(pc_in), .o_pc_oe(pc_oe), .o_pc_inc(pc_inc), .o_pc_dec(pc_dec),
        .o_pc_flush(pc_flush), .o_mem_req(mem_req), .o_mem_addr(mem_addr),
        .i_mem_ack(ack), .i_mem_rdata(rdata), .o_instr_valid(instr_valid),
        .i_instr_ready(ready), .o_instr_data(instr_data), .o_instr_pc(instr_pc),
        .o_fetch_cnt(fetch_cnt)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Program counter environment: tristate output seen only while pc_oe
    logic [AW-1:0] env_pc;
    logic          env_load = 0;
    logic [AW-1:0] env_val = '0;
    assign pc_in = pc_oe ? env_pc : 12'hA5A;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        env_pc <= '0;
        else if (env_load) env_pc <= env_val;
        else if (pc_flush) env_pc <= '0;
        else if (pc_inc)   env_pc <= env_pc + 1'b1;
        else if (pc_dec)   env_pc <= env_pc - 1'b1;
    end

    // Memory: acks after a random number of wait cycles, or manually driven
    logic          auto_ack = 1, man_ack = 0, r_auto = 0;
    logic          fixed_en = 0;
    logic [DW-1:0] fixed_data = '0;
    int            lat_lo = 0, lat_hi = 0, wait_n = 0, lat_cur = 0;
    assign ack = auto_ack ? r_auto : man_ack;
    always @(posedge clk) begin
        #1;
        rdata = fixed_en ? fixed_data : DW'($urandom);
        if (mem_req) begin
            if (wait_n >= lat_cur) begin r_auto = 1; wait_n = 0; end
            else begin r_auto = 0; wait_n++; end
        end else begin
            r_auto = 0; wait_n = 0; lat_cur = $urandom_range(lat_hi, lat_lo);
        end
    end

    // Reference: one request slot, one holding slot, and the pulse last issued
    logic          m_req, m_drain, m_valid, m_inc, m_dec, m_flush;
    logic [AW-1:0] m_addr, m_ipc;
    logic [DW-1:0] m_data;
    logic [CW-1:0] m_cnt;
    logic          cnt_load = 0;
    always @(posedge clk or negedge rst_n) begin : mdl
        logic was_idle, settling;
        if (!rst_n) begin
            m_req = 0; m_drain = 0; m_valid = 0; m_inc = 0; m_dec = 0; m_flush = 0;
            m_addr = '0; m_ipc = '0; m_data = '0; m_cnt = '0;
        end else begin
            was_idle = !m_req && !m_valid;
            settling = m_inc || m_dec || m_flush;
            m_inc = 0; m_dec = 0; m_flush = flush;
            if (cnt_load) m_cnt = 16'hFFFF;
            if (flush) begin
                m_valid = 0;
                if (m_req && ack) begin m_req = 0; m_drain = 0; end
                else if (m_req) m_drain = 1;
            end else if (was_idle) begin
                if (run && !settling) begin m_req = 1; m_addr = pc_in; m_drain = 0; end
            end else if (m_req) begin
                if (ack) begin
                    if (!m_drain) begin m_valid = 1; m_data = rdata; m_ipc = m_addr; m_inc = 1; end
                    m_req = 0; m_drain = 0;
                end
            end else if (replay) begin
                m_valid = 0; m_dec = 1;
            end else if (ready) begin
                m_valid = 0; m_cnt = m_cnt + 1'b1;
            end
        end
    end

    logic cmp_cnt_en = 1;
    always @(negedge clk) begin
        if (rst_n) begin
            check("pc_oe", pc_oe, !m_req && !m_valid);
            check("pc_inc", pc_inc, m_inc);
            check("pc_dec", pc_dec, m_dec);
            check("pc_flush", pc_flush, m_flush);
            check("mem_req", mem_req, m_req);
            check("mem_addr", mem_addr, m_addr);
            check("instr_valid", instr_valid, m_valid);
            if (m_valid) check("instr_data", instr_data, m_data);
            if (m_valid) check("instr_pc", instr_pc, m_ipc);
            if (cmp_cnt_en) check("fetch_cnt", fetch_cnt, m_cnt);
        end
    end

    // Observation of issued addresses and pulses for the directed cases
    logic [AW-1:0] issued[$];
    logic          prev_req = 0;
    int            inc_n = 0, dec_n = 0, fl_n = 0;
    logic          saw_5a = 0;
    always @(negedge clk) begin
        if (mem_req && !prev_req) issued.push_back(mem_addr);
        prev_req = mem_req;
        inc_n += int'(pc_inc);
        dec_n += int'(pc_dec);
        fl_n  += int'(pc_flush);
        if (instr_valid && instr_pc == 12'h05A) saw_5a = 1;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_req();
        for (int k = 0; k < 40 && !m_req; k++) tick();
        check("wait_req", {31'b0, m_req}, 32'd1);
    endtask

    task automatic wait_valid();
        for (int k = 0; k < 40 && !m_valid; k++) tick();
        check("wait_valid", {31'b0, m_valid}, 32'd1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40 && (m_req || m_valid || m_inc || m_dec || m_flush); k++) tick();
        check("wait_idle", {31'b0, (m_req || m_valid || m_inc || m_dec || m_flush)}, 32'd0);
    endtask

    task automatic fetch_one();
        run = 1; wait_req(); run = 0;
    endtask

    task automatic load_pc(input logic [AW-1:0] v);
        env_val = v; env_load = 1; tick(); env_load = 0;
    endtask

    initial begin
        rst_n = 0;
        repeat (3) tick();
        check("rst_mem_req", mem_req, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_cnt", fetch_cnt, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_data", instr_data, 0);
        check("rst_pc_oe", pc_oe, 1);
        rst_n = 1;
        tick();

        // Sequential fetches from 0 with one-cycle memory latency
        lat_lo = 1; lat_hi = 1; ready = 1;
        issued.delete(); inc_n = 0;
        for (int i = 0; i < 3; i++) begin fetch_one(); wait_idle(); end
        check("seq_n", issued.size(), 3);
        for (int i = 0; i < 3 && i < issued.size(); i++) check("seq_addr", issued[i], i);
        check("seq_inc", inc_n, 3);
        check("seq_cnt", fetch_cnt, 3);

        // Decode stalls for five cycles on 0xBEEF at 0x010
        ready = 0; fixed_en = 1; fixed_data = 16'hBEEF;
        load_pc(12'h010);
        issued.delete();
        fetch_one(); wait_valid();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", instr_valid, 1);
            check("hold_data", instr_data, 16'hBEEF);
            check("hold_pc", instr_pc, 12'h010);
            check("hold_req", mem_req, 0);
        end
        check("hold_issued", issued.size(), 1);
        check("hold_pc_once", env_pc, 12'h011);
        ready = 1; tick(); ready = 0; fixed_en = 0;
        wait_idle();

        // Replay wins over ready and refetches the same address
        load_pc(12'h020);
        fetch_one(); wait_valid();
        dec_n = 0;
        replay = 1; ready = 1; tick(); replay = 0; ready = 0;
        wait_idle();
        check("replay_dec", dec_n, 1);
        check("replay_cnt", fetch_cnt, 4);
        check("replay_pc", env_pc, 12'h020);
        fetch_one();
        check("replay_addr", mem_addr, 12'h020);
        ready = 1; wait_idle(); ready = 0;

        // Flush during a stalled request drains the late ack
        load_pc(12'h05A);
        auto_ack = 0; man_ack = 0; saw_5a = 0; fl_n = 0;
        fetch_one(); tick();
        flush = 1; tick(); flush = 0;
        repeat (3) tick();
        check("drain_req", mem_req, 1);
        man_ack = 1; tick(); man_ack = 0; auto_ack = 1;
        wait_idle();
        check("flush_pulses", fl_n, 1);
        check("flush_no_5a", saw_5a, 0);
        fetch_one();
        check("flush_addr", mem_addr, 12'h000);
        ready = 1; wait_idle(); ready = 0;

        // Asynchronous reset while holding an instruction
        fetch_one(); wait_valid();
        rst_n = 0;
        #1;
        check("arst_valid", instr_valid, 0);
        check("arst_req", mem_req, 0);
        check("arst_pulses", {pc_inc, pc_dec, pc_flush}, 0);
        check("arst_cnt", fetch_cnt, 0);
        tick(); tick();
        rst_n = 1; tick();
        ready = 1; fetch_one(); wait_idle(); ready = 0;
        check("arst_resume_cnt", fetch_cnt, 1);

        // Counter wrap from all-ones
        cmp_cnt_en = 0;
        force dut.r_fetch_cnt = 16'hFFFF;
        cnt_load = 1; tick(); cnt_load = 0;
        release dut.r_fetch_cnt;
        cmp_cnt_en = 1;
        check("wrap_pre", fetch_cnt, 16'hFFFF);
        ready = 1; fetch_one(); wait_idle(); ready = 0;
        check("wrap_cnt", fetch_cnt, 16'h0000);

        // Random traffic
        lat_lo = 0; lat_hi = 3;
        for (int i = 0; i < 3000; i++) begin
            run    = ($urandom_range(3, 0) != 0);
            flush  = ($urandom_range(15, 0) == 0);
            replay = ($urandom_range(7, 0) == 0);
            ready  = $urandom_range(1, 0) != 0;
            if (i == 1500) begin
                rst_n = 0; tick(); tick(); rst_n = 1;
            end
            tick();
        end
        run = 0; flush = 0; replay = 0; ready = 1;
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
